// File: rtl/trellis_pixel_sync.sv
// trellis_pixel_sync: keeps the NeoTrellis LED grid in step with sequencer state.
// Sweeps the pixels round-robin, sends a NEOPIXEL_BUF write for each pixel whose
// colour differs from what the panel last acknowledged, then a NEOPIXEL_SHOW.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_SCAN      | inspect one pixel per cycle, pick the next write
//   S_ISSUE     | raise i2c_enable for one cycle
//   S_WAIT_ACK  | wait for i2c_busy to rise, give up after ACK_TIMEOUT
//   S_WAIT_DONE | wait for i2c_busy to fall, commit the transaction
//   S_GAP       | idle GAP_CYCLES so the seesaw can digest the write
module trellis_pixel_sync #(
  parameter int          NUM_BEATS   = 16,
  parameter logic [6:0]  DEVICE_ADDR = 7'h2E,
  parameter logic [15:0] I2C_DIVIDER = 16'd29,
  parameter int          GAP_CYCLES  = 1200,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BEATS*4-1:0]       beats,
  input  logic [$clog2(NUM_BEATS)-1:0] beat_count,
  input  logic                         i2c_busy,
  output logic                         i2c_enable,
  output logic                         i2c_read_write,
  output logic [6:0]                   i2c_device_address,
  output logic [15:0]                  i2c_divider,
  output logic [15:0]                  i2c_register_address,
  output logic [39:0]                  i2c_mosi_data,
  output logic                         frame_done,
  output logic                         timeout_error
);

  localparam int PW = $clog2(NUM_BEATS);
  localparam int CW = $clog2(NUM_BEATS + 1);
  localparam int TW = $clog2(((GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT) + 1);
  localparam logic [15:0] REG_BUF  = 16'h0E04;
  localparam logic [15:0] REG_SHOW = 16'h0E05;

  typedef enum logic [2:0] {
    S_SCAN,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  idx;
  logic [CW-1:0]  clean_cnt;
  logic [TW-1:0]  timer;
  logic [4:0]     code_lat;
  logic           kind_show;
  logic           pending_show;
  logic [4:0]     shadow [NUM_BEATS];
  logic [NUM_BEATS-1:0] shadow_valid;

  logic [3:0]     cur_pitch;
  logic           cur_play;
  logic [4:0]     cur_code;
  logic           cur_dirty;
  logic [7:0]     col_g;
  logic [7:0]     col_r;
  logic [7:0]     col_b;
  logic [7:0]     cur_offset;
  logic [CW-1:0]  clean_next;
  logic [PW-1:0]  ptr_next;

  assign i2c_read_write     = 1'b0;
  assign i2c_device_address = DEVICE_ADDR;
  assign i2c_divider        = I2C_DIVIDER;

  // Desired colour and dirty status of the pixel under the scan pointer
  always_comb begin
    cur_pitch  = beats[{ptr, 2'b00} +: 4];
    cur_play   = (ptr == beat_count);
    cur_code   = {cur_play, cur_pitch};
    cur_dirty  = !shadow_valid[ptr] || (shadow[ptr] != cur_code);
    cur_offset = 8'(ptr) * 8'd3;
    clean_next = clean_cnt + 1'b1;
    ptr_next   = (ptr == PW'(NUM_BEATS - 1)) ? '0 : ptr + 1'b1;
    col_g      = 8'h00;
    col_r      = 8'h00;
    col_b      = 8'h00;
    if (cur_play) begin
      col_g = 8'hFF;
      col_r = 8'hFF;
      col_b = 8'hFF;
    end else if (cur_pitch != 4'h0) begin
      col_g = {cur_pitch, 4'h0};
      col_b = {~cur_pitch, 4'h0};
    end
  end

  // Shadow records the code latched at issue time, only once the panel has taken it
  always_ff @(posedge clk) begin
    if (!rst && state == S_WAIT_DONE && !i2c_busy && !kind_show)
      shadow[idx] <= code_lat;
  end

  // Main sequencing FSM with registered i2c request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_SCAN;
      ptr                  <= '0;
      idx                  <= '0;
      clean_cnt            <= '0;
      timer                <= '0;
      code_lat             <= '0;
      kind_show            <= 1'b0;
      pending_show         <= 1'b0;
      shadow_valid         <= '0;
      i2c_enable           <= 1'b0;
      i2c_register_address <= REG_BUF;
      i2c_mosi_data        <= '0;
      frame_done           <= 1'b0;
      timeout_error        <= 1'b0;
    end else begin
      i2c_enable <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_SCAN: begin
          ptr <= ptr_next;
          if (cur_dirty) begin
            idx                  <= ptr;
            code_lat             <= cur_code;
            kind_show            <= 1'b0;
            i2c_register_address <= REG_BUF;
            i2c_mosi_data        <= {8'h00, cur_offset, col_g, col_r, col_b};
            clean_cnt            <= '0;
            state                <= S_ISSUE;
          end else if (clean_next == CW'(NUM_BEATS)) begin
            clean_cnt <= '0;
            if (pending_show) begin
              kind_show            <= 1'b1;
              i2c_register_address <= REG_SHOW;
              i2c_mosi_data        <= '0;
              state                <= S_ISSUE;
            end
          end else begin
            clean_cnt <= clean_next;
          end
        end
        S_ISSUE: begin
          i2c_enable <= 1'b1;
          timer      <= TW'(ACK_TIMEOUT);
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i2c_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer <= TW'(1)) begin
            // no response from the master: drop this write, the pixel stays dirty
            timeout_error <= 1'b1;
            timer         <= TW'(GAP_CYCLES);
            state         <= S_GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i2c_busy) begin
            if (kind_show) begin
              pending_show <= 1'b0;
              frame_done   <= 1'b1;
            end else begin
              shadow_valid[idx] <= 1'b1;
              pending_show      <= 1'b1;
            end
            timer <= TW'(GAP_CYCLES);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer <= TW'(1))
            state <= S_SCAN;
          else
            timer <= timer - 1'b1;
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_trellis_pixel_sync.sv
// Scoreboard bench for trellis_pixel_sync: stimulus pushes the expected i2c
// writes into a queue, a monitor pops and compares on every i2c_enable.
module tb_trellis_pixel_sync;

  localparam int NB    = 16;
  localparam int GAP   = 1200;
  localparam int ACKTO = 64;
  localparam logic [55:0] SHOW = {16'h0E05, 40'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] beats;
  logic [3:0]  beat_count;
  logic        i2c_busy;
  logic        i2c_enable;
  logic        i2c_read_write;
  logic [6:0]  i2c_device_address;
  logic [15:0] i2c_divider;
  logic [15:0] i2c_register_address;
  logic [39:0] i2c_mosi_data;
  logic        frame_done;
  logic        timeout_error;

  trellis_pixel_sync dut (
    .clk                  (clk),
    .rst                  (rst),
    .beats                (beats),
    .beat_count           (beat_count),
    .i2c_busy             (i2c_busy),
    .i2c_enable           (i2c_enable),
    .i2c_read_write       (i2c_read_write),
    .i2c_device_address   (i2c_device_address),
    .i2c_divider          (i2c_divider),
    .i2c_register_address (i2c_register_address),
    .i2c_mosi_data        (i2c_mosi_data),
    .frame_done           (frame_done),
    .timeout_error        (timeout_error)
  );

  always #5 clk = ~clk;

  int compared    = 0;
  int mismatched  = 0;
  int cyc         = 0;
  int en_count    = 0;
  int fd_count    = 0;
  int last_en_cyc = -1;
  bit no_ack      = 1'b0;
  logic [55:0] expq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] pix(input int i, input logic [3:0] p, input bit play);
    logic [7:0] g, r, b;
    g = 8'h00; r = 8'h00; b = 8'h00;
    if (play) begin
      g = 8'hFF; r = 8'hFF; b = 8'hFF;
    end else if (p != 4'h0) begin
      g = {p, 4'h0}; b = {~p, 4'h0};
    end
    return {16'h0E04, 8'h00, 8'(3 * i), g, r, b};
  endfunction

  // i2c_master stand-in: busy rises 2 cycles after enable, lasts 6 cycles
  initial begin
    i2c_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_enable && !no_ack) begin
        repeat (2) @(negedge clk);
        i2c_busy = 1'b1;
        repeat (6) @(negedge clk);
        i2c_busy = 1'b0;
      end
    end
  end

  // Monitor: compare every issued write against the scoreboard
  always @(negedge clk) begin
    logic [55:0] e;
    if (rst) begin
      last_en_cyc = -1;
    end else begin
      if (frame_done) fd_count++;
      if (i2c_enable) begin
        en_count++;
        check("const_fields", 64'({i2c_read_write, i2c_device_address, i2c_divider}),
              64'({1'b0, 7'h2E, 16'd29}));
        if (last_en_cyc >= 0)
          check("enable_spacing", 64'((cyc - last_en_cyc) >= GAP), 64'd1);
        last_en_cyc = cyc;
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got reg %h data %h expected none",
                   i2c_register_address, i2c_mosi_data);
        end else begin
          e = expq.pop_front();
          check("write", 64'({i2c_register_address, i2c_mosi_data}), 64'(e));
        end
      end
    end
  end

  task automatic wait_en(input int target, input int budget, input string name);
    int n = 0;
    while (en_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(en_count >= target), 64'd1);
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(fd_count), 64'(target));
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!i2c_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(i2c_busy), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_enable"},  64'(i2c_enable), 64'd0);
    check({tag, "_regaddr"}, 64'(i2c_register_address), 64'h0E04);
    check({tag, "_mosi"},    64'(i2c_mosi_data), 64'd0);
    check({tag, "_frame"},   64'(frame_done), 64'd0);
    check({tag, "_timeout"}, 64'(timeout_error), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int n;
    logic [3:0] p;
    rst        = 1'b1;
    beats      = '0;
    beat_count = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // full refresh from reset: playhead white on pixel 0, everything else off
    for (int i = 0; i < NB; i++) expq.push_back(pix(i, 4'h0, i == 0));
    expq.push_back(SHOW);
    rst = 1'b0;
    wait_fd(1, 30000, "p1_frame");
    repeat (3000) @(negedge clk);
    check("p1_frames_total", 64'(fd_count), 64'd1);
    check("p1_writes_total", 64'(en_count), 64'd17);
    check("p1_queue_empty", 64'(expq.size()), 64'd0);

    // single beat edit
    expq.push_back({16'h0E04, 40'h00_0F_A0_00_50});
    expq.push_back(SHOW);
    beats[23:20] = 4'hA;
    wait_fd(2, 6000, "p2_frame");
    check("p2_queue_empty", 64'(expq.size()), 64'd0);

    // playhead move while the pointer sits at pixel 6 during the gap
    expq.push_back({16'h0E04, 40'h00_00_00_00_00});
    expq.push_back({16'h0E04, 40'h00_03_FF_FF_FF});
    expq.push_back(SHOW);
    beat_count = 4'd1;
    wait_fd(3, 8000, "p3_frame");
    check("p3_queue_empty", 64'(expq.size()), 64'd0);

    // master never answers: timeout, retry of the same pixel, no frame
    no_ack = 1'b1;
    base = en_count;
    expq.push_back({16'h0E04, 40'h00_06_30_00_C0});
    expq.push_back({16'h0E04, 40'h00_06_30_00_C0});
    beats[11:8] = 4'h3;
    wait_en(base + 1, 3000, "p4_first_try");
    t0 = last_en_cyc;
    n = 0;
    while (!timeout_error && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p4_timeout_latency", 64'(cyc - t0), 64'(ACKTO));
    wait_en(base + 2, 3000, "p4_retry");
    @(negedge clk);
    no_ack = 1'b0;
    check("p4_no_frame", 64'(fd_count), 64'd3);
    expq.push_back({16'h0E04, 40'h00_06_30_00_C0});
    expq.push_back(SHOW);
    wait_fd(4, 8000, "p4_frame");
    check("p4_timeout_sticky", 64'(timeout_error), 64'd1);
    check("p4_queue_empty", 64'(expq.size()), 64'd0);

    // beat edited while its own write is in flight: resent before the show
    expq.push_back({16'h0E04, 40'h00_0F_10_00_E0});
    expq.push_back({16'h0E04, 40'h00_0F_70_00_80});
    expq.push_back(SHOW);
    base = en_count;
    beats[23:20] = 4'h1;
    wait_en(base + 1, 3000, "p5_first_write");
    wait_busy("p5_busy");
    beats[23:20] = 4'h7;
    wait_fd(5, 8000, "p5_frame");
    check("p5_queue_empty", 64'(expq.size()), 64'd0);

    // reset in the middle of a transfer, then a full refresh
    expq.push_back({16'h0E04, 40'h00_18_F0_00_00});
    base = en_count;
    beats[35:32] = 4'hF;
    wait_en(base + 1, 3000, "p6_write");
    wait_busy("p6_busy");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    repeat (20) @(negedge clk);
    check("p6_abandoned_popped", 64'(expq.size()), 64'd0);
    for (int i = 0; i < NB; i++) begin
      p = beats[4*i +: 4];
      expq.push_back(pix(i, p, i == 1));
    end
    expq.push_back(SHOW);
    base = en_count;
    rst = 1'b0;
    wait_fd(6, 30000, "p6_frame");
    check("p6_writes_total", 64'(en_count - base), 64'd17);
    check("p6_queue_empty", 64'(expq.size()), 64'd0);
    check("p6_timeout_clear", 64'(timeout_error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
